// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM macro between NREQ requesters.
// Round-robin arbitration with optional locked (burst) ownership and an
// idle timeout that forcibly releases a lock whose owner stops issuing beats.
// Read data comes back one cycle after the accepted read beat.
module sram_port_arbiter #(
  parameter int NREQ         = 2,
  parameter int AW           = 14,
  parameter int DW           = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ-1:0]        req_write_i,
  input  logic [NREQ-1:0]        req_lock_i,
  input  logic [NREQ*AW-1:0]     req_addr_i,
  input  logic [NREQ*DW-1:0]     req_wdata_i,
  input  logic [NREQ*DW/8-1:0]   req_wstrb_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic [NREQ-1:0]        rsp_valid_o,
  output logic [DW-1:0]          rsp_rdata_o,
  output logic                   sram_cs_o,
  output logic [DW/8-1:0]        sram_web_o,
  output logic [AW-1:0]          sram_a_o,
  output logic [DW-1:0]          sram_di_o,
  input  logic [DW-1:0]          sram_do_i,
  output logic                   lock_timeout_o
);

  localparam int BW = DW / 8;
  localparam int PW = $clog2(NREQ);
  localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (LOCK_TIMEOUT > 0) ? CW'(LOCK_TIMEOUT - 1) : '0;

  typedef enum logic {ARB, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     idleCnt_q, idleCnt_d;
  logic [NREQ-1:0]   rspValid_q, rspValid_d;
  logic [AW-1:0]     addrHold_q;
  logic [DW-1:0]     dataHold_q;

  logic [PW-1:0]     grantIdx;
  logic              grantValid;
  logic              accept;
  logic              ownerValid;
  logic              lockExpire;
  logic              selWrite;
  logic              selLock;
  logic [AW-1:0]     selAddr;
  logic [DW-1:0]     selData;
  logic [BW-1:0]     selStrb;

  // Pick the winner: the owner while locked, otherwise the first valid
  // requester at or after ptr, wrapping to the lowest valid index below ptr.
  always_comb begin
    grantIdx   = '0;
    grantValid = 1'b0;
    ownerValid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == PW'(i)) ownerValid = req_valid_i[i];
    end
    if (state_q == LOCKED) begin
      grantIdx   = owner_q;
      grantValid = ownerValid;
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req_valid_i[i]) begin
          grantIdx   = PW'(i);
          grantValid = 1'b1;
        end
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req_valid_i[i] && (PW'(i) >= ptr_q)) begin
          grantIdx   = PW'(i);
          grantValid = 1'b1;
        end
      end
    end
  end

  // Route the winning requester's beat onto the SRAM pins; hold the address
  // and data pins steady when the port is idle so they do not toggle.
  always_comb begin
    selWrite = 1'b0;
    selLock  = 1'b0;
    selAddr  = '0;
    selData  = '0;
    selStrb  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grantIdx == PW'(i)) begin
        selWrite = req_write_i[i];
        selLock  = req_lock_i[i];
        selAddr  = req_addr_i[i*AW +: AW];
        selData  = req_wdata_i[i*DW +: DW];
        selStrb  = req_wstrb_i[i*BW +: BW];
      end
    end
    accept     = grantValid && !rst;
    lockExpire = (LOCK_TIMEOUT != 0) && !rst && (state_q == LOCKED) &&
                 !ownerValid && (idleCnt_q == CNT_LAST);
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = accept && (grantIdx == PW'(i));
    end
    sram_cs_o      = accept;
    sram_web_o     = (accept && selWrite) ? ~selStrb : '1;
    sram_a_o       = accept ? selAddr : addrHold_q;
    sram_di_o      = accept ? selData : dataHold_q;
    rsp_valid_o    = rst ? '0 : rspValid_q;
    rsp_rdata_o    = sram_do_i;
    lock_timeout_o = lockExpire;
  end

  // Next-state: advance the round-robin pointer, track lock ownership and
  // count owner idle cycles towards the forced release.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    idleCnt_d  = idleCnt_q;
    rspValid_d = '0;
    if (accept) begin
      ptr_d = (grantIdx == PW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        rspValid_d[i] = !selWrite && (grantIdx == PW'(i));
      end
    end
    case (state_q)
      ARB: begin
        if (accept && selLock) begin
          state_d   = LOCKED;
          owner_d   = grantIdx;
          idleCnt_d = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          idleCnt_d = '0;
          if (!selLock) state_d = ARB;
        end else if (lockExpire) begin
          state_d   = ARB;
          idleCnt_d = '0;
        end else if (idleCnt_q != CNT_MAX) begin
          idleCnt_d = idleCnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Control state; reset also drops any read response still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      idleCnt_q  <= '0;
      rspValid_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      idleCnt_q  <= idleCnt_d;
      rspValid_q <= rspValid_d;
    end
  end

  // Remember the last driven address/data so idle cycles repeat them.
  always_ff @(posedge clk) begin
    if (accept) begin
      addrHold_q <= selAddr;
      dataHold_q <= selData;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios followed by random traffic, all
// compared cycle by cycle against a behavioural arbiter/SRAM model.
module tb_sram_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int LT   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      reqValid = '0;
  logic [NREQ-1:0]      reqWrite = '0;
  logic [NREQ-1:0]      reqLock = '0;
  logic [NREQ*AW-1:0]   reqAddr = '0;
  logic [NREQ*DW-1:0]   reqWdata = '0;
  logic [NREQ*BW-1:0]   reqWstrb = '0;
  logic [NREQ-1:0]      reqReady;
  logic [NREQ-1:0]      rspValid;
  logic [DW-1:0]        rspRdata;
  logic                 sramCs;
  logic [BW-1:0]        sramWeb;
  logic [AW-1:0]        sramA;
  logic [DW-1:0]        sramDi;
  logic [DW-1:0]        sramDo = '0;
  logic                 lockTimeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [DW-1:0] sramMem [0:(1<<AW)-1];
  logic [DW-1:0] refMem  [0:(1<<AW)-1];
  int            mPtr = 0;
  bit            mLocked = 0;
  int            mOwner = 0;
  int            mIdle = 0;
  bit            mPend = 0;
  int            mPendIdx = 0;
  logic [DW-1:0] mPendData = '0;
  bit            mLastKnown = 0;
  logic [AW-1:0] mLastA = '0;
  logic [DW-1:0] mLastDi = '0;

  // Observed values of the most recent cycle, for the directed checks
  logic [NREQ-1:0] obsReady;
  logic [NREQ-1:0] obsRspValid;
  logic [DW-1:0]   obsRdata;
  logic [BW-1:0]   obsWeb;
  logic            obsCs;
  logic            obsTo;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (reqValid),
    .req_write_i    (reqWrite),
    .req_lock_i     (reqLock),
    .req_addr_i     (reqAddr),
    .req_wdata_i    (reqWdata),
    .req_wstrb_i    (reqWstrb),
    .req_ready_o    (reqReady),
    .rsp_valid_o    (rspValid),
    .rsp_rdata_o    (rspRdata),
    .sram_cs_o      (sramCs),
    .sram_web_o     (sramWeb),
    .sram_a_o       (sramA),
    .sram_di_o      (sramDi),
    .sram_do_i      (sramDo),
    .lock_timeout_o (lockTimeout)
  );

  // SRAM macro model driven purely by the DUT pins
  always @(posedge clk) begin
    if (sramCs) begin
      if (&sramWeb) begin
        sramDo <= sramMem[sramA];
      end else begin
        for (int b = 0; b < BW; b++) begin
          if (!sramWeb[b]) sramMem[sramA][8*b +: 8] = sramDi[8*b +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int i, input logic v, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] s);
    reqValid[i] = v;
    reqWrite[i] = w;
    reqLock[i]  = l;
    reqAddr[i*AW +: AW] = a;
    reqWdata[i*DW +: DW] = d;
    reqWstrb[i*BW +: BW] = s;
  endtask

  task automatic clearReqs();
    reqValid = '0;
    reqWrite = '0;
    reqLock  = '0;
  endtask

  // One clock cycle: predict the outputs from the arbitration rules, compare,
  // advance the model, then move to just after the next rising edge.
  task automatic applyStimulus();
    int              g;
    logic            expTo;
    logic [NREQ-1:0] expReady;
    logic [NREQ-1:0] expRsp;
    logic [BW-1:0]   expWeb;
    logic [AW-1:0]   gA;
    logic [DW-1:0]   gD;
    logic [BW-1:0]   gS;
    #3;
    g = -1;
    gA = '0;
    gD = '0;
    gS = '0;
    if (!rst) begin
      if (mLocked) begin
        if (reqValid[mOwner]) g = mOwner;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (mPtr + k) % NREQ;
          if (g < 0 && reqValid[i]) g = i;
        end
      end
    end
    expTo    = !rst && mLocked && !reqValid[mOwner] && (mIdle == LT - 1);
    expReady = '0;
    expWeb   = '1;
    if (g >= 0) begin
      expReady[g] = 1'b1;
      gA = reqAddr[g*AW +: AW];
      gD = reqWdata[g*DW +: DW];
      gS = reqWstrb[g*BW +: BW];
      if (reqWrite[g]) expWeb = ~gS;
    end
    expRsp = '0;
    if (mPend && !rst) expRsp[mPendIdx] = 1'b1;

    obsReady    = reqReady;
    obsRspValid = rspValid;
    obsRdata    = rspRdata;
    obsWeb      = sramWeb;
    obsCs       = sramCs;
    obsTo       = lockTimeout;

    checkOutput("req_ready", reqReady, expReady);
    checkOutput("sram_cs", sramCs, (g >= 0));
    checkOutput("sram_web", sramWeb, expWeb);
    if (g >= 0) begin
      checkOutput("sram_a", sramA, gA);
      checkOutput("sram_di", sramDi, gD);
    end else if (mLastKnown) begin
      checkOutput("sram_a_hold", sramA, mLastA);
      checkOutput("sram_di_hold", sramDi, mLastDi);
    end
    checkOutput("rsp_valid", rspValid, expRsp);
    if (mPend && !rst) checkOutput("rsp_rdata", rspRdata, mPendData);
    checkOutput("lock_timeout", lockTimeout, expTo);

    if (rst) begin
      mPtr = 0;
      mLocked = 0;
      mIdle = 0;
      mPend = 0;
    end else begin
      mPend = 0;
      if (g >= 0) begin
        mPtr = (g + 1) % NREQ;
        mLastKnown = 1;
        mLastA = gA;
        mLastDi = gD;
        if (reqWrite[g]) begin
          for (int b = 0; b < BW; b++) begin
            if (gS[b]) refMem[gA][8*b +: 8] = gD[8*b +: 8];
          end
        end else begin
          mPend = 1;
          mPendIdx = g;
          mPendData = refMem[gA];
        end
        if (!mLocked) begin
          if (reqLock[g]) begin
            mLocked = 1;
            mOwner = g;
            mIdle = 0;
          end
        end else begin
          mIdle = 0;
          if (!reqLock[g]) mLocked = 0;
        end
      end else if (mLocked) begin
        if (expTo) begin
          mLocked = 0;
          mIdle = 0;
        end else begin
          mIdle++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int toCycle;
    logic [NREQ-1:0] toReady;
    int pv;

    for (int a = 0; a < (1 << AW); a++) begin
      sramMem[a] = '0;
      refMem[a]  = '0;
    end
    sramMem[14'h10] = 32'h1111_1111;
    refMem[14'h10]  = 32'h1111_1111;
    sramMem[14'h20] = 32'h2222_2222;
    refMem[14'h20]  = 32'h2222_2222;
    #1;

    $display("[TB] reset with all requesters valid");
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    for (int c = 0; c < 2; c++) begin
      applyStimulus();
      checkOutput("rst_ready", obsReady, 3'b000);
      checkOutput("rst_cs", obsCs, 1'b0);
      checkOutput("rst_web", obsWeb, 4'hF);
      checkOutput("rst_rsp_valid", obsRspValid, 3'b000);
    end
    rst = 1'b0;
    applyStimulus();
    checkOutput("rst_first_grant", obsReady, 3'b001);
    clearReqs();
    applyStimulus();

    $display("[TB] round-robin reads");
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    setReq(0, 1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 4'h0);
    setReq(1, 1'b1, 1'b0, 1'b0, 14'h20, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      if (c < 4) checkOutput("rr_grant", obsReady, (c % 2 == 0) ? 3'b001 : 3'b010);
      if (c > 0) begin
        checkOutput("rr_rsp_valid", obsRspValid, ((c - 1) % 2 == 0) ? 3'b001 : 3'b010);
        checkOutput("rr_rsp_data", obsRdata, ((c - 1) % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
      end
    end
    clearReqs();
    applyStimulus();

    $display("[TB] partial write then read back");
    setReq(1, 1'b1, 1'b1, 1'b0, 14'h5, 32'hDEAD_BEEF, 4'b0011);
    applyStimulus();
    checkOutput("wr_cs", obsCs, 1'b1);
    checkOutput("wr_web", obsWeb, 4'b1100);
    clearReqs();
    applyStimulus();
    setReq(1, 1'b1, 1'b0, 1'b0, 14'h5, 32'h0, 4'h0);
    applyStimulus();
    clearReqs();
    applyStimulus();
    checkOutput("rd_rsp_valid", obsRspValid, 3'b010);
    checkOutput("rd_rsp_data", obsRdata, 32'h0000_BEEF);

    $display("[TB] locked burst blocks the other requester");
    setReq(1, 1'b1, 1'b0, 1'b0, 14'h20, 32'h0, 4'h0);
    for (int b = 0; b < 4; b++) begin
      setReq(0, 1'b1, 1'b0, (b < 3), 14'h10, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("lock_grant", obsReady, 3'b001);
    end
    setReq(0, 1'b0, 1'b0, 1'b0, 14'h10, 32'h0, 4'h0);
    applyStimulus();
    checkOutput("lock_release_grant", obsReady, 3'b010);
    clearReqs();
    applyStimulus();

    $display("[TB] lock idle timeout");
    setReq(0, 1'b1, 1'b0, 1'b1, 14'h10, 32'h0, 4'h0);
    setReq(1, 1'b1, 1'b0, 1'b0, 14'h20, 32'h0, 4'h0);
    applyStimulus();
    checkOutput("to_lock_beat", obsReady, 3'b001);
    setReq(0, 1'b0, 1'b0, 1'b0, 14'h10, 32'h0, 4'h0);
    toCycle = -1;
    toReady = '1;
    for (int c = 1; c <= 40 && toCycle < 0; c++) begin
      applyStimulus();
      if (obsTo) begin
        toCycle = c;
        toReady = obsReady;
      end
    end
    checkOutput("to_pulse_cycle", toCycle, 16);
    checkOutput("to_pulse_ready", toReady, 3'b000);
    applyStimulus();
    checkOutput("to_after_grant", obsReady, 3'b010);
    checkOutput("to_single_pulse", obsTo, 1'b0);
    clearReqs();
    applyStimulus();

    $display("[TB] reset during an in-flight read");
    setReq(0, 1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 4'h0);
    applyStimulus();
    checkOutput("mid_read_grant", obsReady, 3'b001);
    clearReqs();
    rst = 1'b1;
    applyStimulus();
    checkOutput("mid_rsp_dropped", obsRspValid, 3'b000);
    rst = 1'b0;
    setReq(0, 1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 4'h0);
    setReq(1, 1'b1, 1'b0, 1'b0, 14'h20, 32'h0, 4'h0);
    applyStimulus();
    checkOutput("mid_next_grant", obsReady, 3'b001);
    clearReqs();
    applyStimulus();

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      pv = (n < 400) ? 60 : 8;
      rst = ($urandom_range(0, 99) < 2);
      for (int i = 0; i < NREQ; i++) begin
        setReq(i, ($urandom_range(0, 99) < pv), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 99) < 40), AW'($urandom_range(0, 31)),
               DW'($urandom), BW'($urandom_range(0, 15)));
      end
      applyStimulus();
    end
    rst = 1'b0;
    clearReqs();
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
